pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Drives the hold and flush controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers from three sources: load-use hazards, EX-stage control-flow redirects and data-memory wait states.
- Adds a post-redirect bubble sequencer, a data-memory wait watchdog and a saturating stall-cycle counter.

Parameters:
- RWIDTH, 5: register index width.
- CWIDTH, 32: stall counter width.
- REDIRECT_BUBBLES, 1: extra IF/ID flush cycles after a redirect, legal range 0..7.
- MEM_TIMEOUT, 255: consecutive dmem wait cycles before mem_err pulses, legal range 1..65535.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- id_rs1  in  RWIDTH  ID-stage source register 1
- id_rs2  in  RWIDTH  ID-stage source register 2
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  RWIDTH  EX-stage destination register
- ex_mem_read  in  1  EX instruction is a load
- ex_redirect  in  1  EX resolved a taken branch, jump or mispredict
- dmem_req  in  1  MEM stage has an active data-memory access
- dmem_ready  in  1  data memory completes the access this cycle
- pc_hold  out  1  PC keeps its value
- ifid_hold  out  1  IF/ID register holds
- idex_hold  out  1  ID/EX register holds
- exmem_hold  out  1  EX/MEM register holds
- ifid_flush  out  1  IF/ID register loads a NOP bubble
- idex_flush  out  1  ID/EX register loads a NOP bubble
- mem_err  out  1  one-cycle watchdog pulse
- stall_cycles  out  CWIDTH  saturating count of cycles with pc_hold=1

Behaviour:
- Hold and flush outputs are combinational from state and inputs, so each acts in the same cycle. mem_err and stall_cycles are registered.
- While rst=1, every hold and flush output is 0, state is RUN, and all counters are 0.
- Internal conditions:
  - mem_stall = dmem_req & ~dmem_ready.
  - load_use = ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
- Priority: mem_stall > ex_redirect > REDIRECT-state bubble > load_use.
- mem_stall (any state):
  - all four holds = 1, both flushes = 0.
  - No state advance except the watchdog.
- ex_redirect (no mem_stall):
  - pc_hold = 0, so the PC loads the target.
  - ifid_flush = 1, idex_flush = 1, all holds = 0.
  - Next state is REDIRECT with bubble count = REDIRECT_BUBBLES, or RUN if the parameter is 0.
  - A new ex_redirect while already in REDIRECT reloads the count.
- REDIRECT state (no mem_stall, no ex_redirect):
  - ifid_flush = 1; the count decrements each cycle.
  - Exit to RUN on the cycle the count reaches 1, after that cycle's flush.
  - load_use is ignored in this state, because ID holds a bubble.
- load_use (RUN, no higher-priority condition):
  - pc_hold = 1, ifid_hold = 1, idex_flush = 1.
  - idex_hold = 0 and exmem_hold = 0, so the load advances.
  - Exactly one bubble per load; the next cycle re-evaluates.
- Otherwise all hold and flush outputs are 0.
- States are RUN, REDIRECT and MEM_WAIT.
  - MEM_WAIT is entered on any cycle with mem_stall.
  - It exits on the first cycle without mem_stall, back to the pre-stall state, with the bubble count preserved.
  - On that release cycle the normal priority rules apply.
- Invariant: hold and flush are never both 1 on the same register.
- Watchdog:
  - Counts consecutive mem_stall cycles.
  - On reaching MEM_TIMEOUT, mem_err pulses for 1 cycle (registered, visible the following cycle) and the counter restarts at 0.
  - The pipeline stays frozen throughout.
  - The counter clears on any cycle without mem_stall.
- stall_cycles increments by 1 on every cycle with pc_hold=1 and saturates at 2^CWIDTH-1 with no wrap.
- Asserting rst mid-stall or mid-redirect returns immediately to RUN with all outputs 0.

Decomposition:
- Shared package pipe_pkg holds:
  - the state encoding (RUN=2'd0, REDIRECT=2'd1, MEM_WAIT=2'd2);
  - the RWIDTH default;
  - the NOP encoding 32'h00000013 used by the flushed pipeline registers.
- One natural sub-module: sat_counter (parameterised width, inc, clear), used for stall_cycles. The watchdog reuses it with its wrap compare done in the parent.

Test Plan:
- load_use case: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for 1 cycle → pc_hold=ifid_hold=idex_flush=1 that cycle, all 0 the next; stall_cycles=1.
- x0 and unused-source cases:
  - ex_rd=0 matching id_rs1=0 → no stall.
  - id_use_rs2=0 with ex_rd==id_rs2 → no stall.
- Redirect with REDIRECT_BUBBLES=2: ex_redirect pulse at cycle N →
  - cycle N: ifid_flush=idex_flush=1, pc_hold=0;
  - cycles N+1 and N+2: ifid_flush=1;
  - cycle N+3: all 0.
- Mem wait: dmem_req=1 with dmem_ready low for 4 cycles → all holds=1 for 4 cycles and stall_cycles=4; release cycle holds=0.
  - Repeat with ex_redirect=1 throughout: the redirect outputs appear only on the release cycle.
- Watchdog with MEM_TIMEOUT=3 and dmem_ready held low for 7 cycles → mem_err pulses twice, each exactly 1 cycle wide; holds stay 1 throughout.
- Reset and saturation:
  - rst asserted during REDIRECT → outputs 0 immediately; after release the state is RUN.
  - CWIDTH=3 with 10 stall cycles → stall_cycles=7.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  localparam int          RWIDTH_DEF = 5;
  localparam logic [31:0] NOP_INSN   = 32'h00000013;  // addi x0, x0, 0
  localparam int          BCNT_W     = 3;
  localparam int          WD_W       = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// rtl/pipe_hazard_ctrl_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage RV32I pipeline
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int RWIDTH           = RWIDTH_DEF,
  parameter int CWIDTH           = 32,
  parameter int REDIRECT_BUBBLES = 1,
  parameter int MEM_TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RWIDTH-1:0] id_rs1,
  input  logic [RWIDTH-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [RWIDTH-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_redirect,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              idex_hold,
  output logic              exmem_hold,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              mem_err,
  output logic [CWIDTH-1:0] stall_cycles
);

  localparam logic [BCNT_W-1:0] BUBBLES   = BCNT_W'(REDIRECT_BUBBLES);
  localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(MEM_TIMEOUT - 1);

  hz_state_t         state_q, state_d;
  hz_state_t         ret_q, ret_d;
  hz_state_t         eff_state;
  logic [BCNT_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]   wd_count;
  logic              mem_stall;
  logic              load_use;
  logic              wd_wrap;

  assign mem_stall = dmem_req & ~dmem_ready;
  assign load_use  = ex_mem_read & (ex_rd != '0) &
                     ((id_use_rs1 & (ex_rd == id_rs1)) | (id_use_rs2 & (ex_rd == id_rs2)));

  // During a memory wait the pipeline behaves as the state it was frozen in.
  assign eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      ret_q   <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    pc_hold    = 1'b0;
    ifid_hold  = 1'b0;
    idex_hold  = 1'b0;
    exmem_hold = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_d    = state_q;
    ret_d      = ret_q;
    cnt_d      = cnt_q;
    if (rst) begin
      state_d = RUN;
    end else if (mem_stall) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_hold  = 1'b1;
      exmem_hold = 1'b1;
      state_d    = MEM_WAIT;
      ret_d      = eff_state;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      cnt_d      = BUBBLES;
      state_d    = (BUBBLES != '0) ? REDIRECT : RUN;
      ret_d      = RUN;
    end else if (eff_state == REDIRECT) begin
      // ID holds a bubble here, so any load-use match is stale.
      ifid_flush = 1'b1;
      if (cnt_q <= BCNT_W'(1)) begin
        cnt_d   = '0;
        state_d = RUN;
      end else begin
        cnt_d   = cnt_q - 1'b1;
        state_d = REDIRECT;
      end
      ret_d = RUN;
    end else begin
      if (load_use) begin
        pc_hold    = 1'b1;
        ifid_hold  = 1'b1;
        idex_flush = 1'b1;
      end
      state_d = RUN;
      ret_d   = RUN;
    end
  end

  sat_counter #(.WIDTH(CWIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .inc   (pc_hold),
    .count (stall_cycles)
  );

  // Watchdog restarts from zero each time it fires, so a long wait pulses periodically.
  assign wd_wrap = (wd_count == WD_LIMIT);

  sat_counter #(.WIDTH(WD_W)) u_wd_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (~mem_stall | wd_wrap),
    .inc   (mem_stall),
    .count (wd_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_err <= 1'b0;
    end else begin
      mem_err <= mem_stall & wd_wrap;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] HALL = 6'b111100;  // {pc,ifid,idex,exmem holds, ifid,idex flushes}
  localparam logic [5:0] LU   = 6'b110001;
  localparam logic [5:0] RD   = 6'b000011;
  localparam logic [5:0] BUB  = 6'b000010;

  typedef struct {
    string      nm;
    logic [5:0] ctl;
    logic       err;
    logic [2:0] stall;
  } exp_t;

  logic       clk, rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, dmem_req, dmem_ready;
  logic       pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_flush, mem_err;
  logic [2:0] stall_cycles;
  logic [5:0] ctl;

  exp_t sb[$];
  exp_t e;
  int   n_run  = 0;
  int   n_fail = 0;

  assign ctl = {pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_flush};

  pipe_hazard_ctrl #(
    .RWIDTH(5), .CWIDTH(3), .REDIRECT_BUBBLES(2), .MEM_TIMEOUT(3)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_hold(idex_hold), .exmem_hold(exmem_hold),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic redir, input logic req, input logic rdy);
    ex_mem_read = mr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2; ex_redirect = redir; dmem_req = req; dmem_ready = rdy;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1, 5, 5, 5, 1, 1, 1, 1, 0);
    sb.push_back('{"reset_outputs", NONE, 1'b0, 3'd0});
    #1;
    e = sb.pop_front(); n_run++;
    if ({ctl, mem_err, stall_cycles} !== {e.ctl, e.err, e.stall}) begin
      n_fail++;
      $display("FAIL %s: got ctl=%b err=%b stall=%0d want ctl=%b err=%b stall=%0d",
               e.nm, ctl, mem_err, stall_cycles, e.ctl, e.err, e.stall);
    end
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      next_cyc();
      case (i)
        0: begin set_in(1, 5, 5, 0, 1, 0, 0, 0, 0); sb.push_back('{"lu_hit_rs1", LU, 1'b0, 3'd0}); end
        1: begin idle(); sb.push_back('{"lu_one_bubble", NONE, 1'b0, 3'd1}); end
        2: begin set_in(1, 0, 0, 0, 1, 1, 0, 0, 0); sb.push_back('{"lu_x0", NONE, 1'b0, 3'd1}); end
        3: begin set_in(1, 7, 3, 7, 1, 0, 0, 0, 0); sb.push_back('{"lu_unused_rs2", NONE, 1'b0, 3'd1}); end
        4: begin set_in(1, 7, 3, 7, 1, 1, 0, 0, 0); sb.push_back('{"lu_hit_rs2", LU, 1'b0, 3'd1}); end
        default: begin idle(); sb.push_back('{"lu_after", NONE, 1'b0, 3'd2}); end
      endcase
      @(negedge clk);
      e = sb.pop_front(); n_run++;
      if ({ctl, mem_err, stall_cycles} !== {e.ctl, e.err, e.stall}) begin
        n_fail++;
        $display("FAIL %s: got ctl=%b err=%b stall=%0d want ctl=%b err=%b stall=%0d",
                 e.nm, ctl, mem_err, stall_cycles, e.ctl, e.err, e.stall);
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      next_cyc();
      case (i)
        0: begin set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); sb.push_back('{"rd_pulse", RD, 1'b0, 3'd0}); end
        1: begin set_in(1, 5, 5, 0, 1, 0, 0, 0, 0); sb.push_back('{"rd_bub1_lu_ignored", BUB, 1'b0, 3'd0}); end
        2: begin idle(); sb.push_back('{"rd_bub2", BUB, 1'b0, 3'd0}); end
        3: begin idle(); sb.push_back('{"rd_done", NONE, 1'b0, 3'd0}); end
        4: begin set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); sb.push_back('{"rd_first", RD, 1'b0, 3'd0}); end
        5: begin set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); sb.push_back('{"rd_reload", RD, 1'b0, 3'd0}); end
        6: begin idle(); sb.push_back('{"rd_reload_bub1", BUB, 1'b0, 3'd0}); end
        7: begin idle(); sb.push_back('{"rd_reload_bub2", BUB, 1'b0, 3'd0}); end
        default: begin idle(); sb.push_back('{"rd_reload_done", NONE, 1'b0, 3'd0}); end
      endcase
      @(negedge clk);
      e = sb.pop_front(); n_run++;
      if ({ctl, mem_err, stall_cycles} !== {e.ctl, e.err, e.stall}) begin
        n_fail++;
        $display("FAIL %s: got ctl=%b err=%b stall=%0d want ctl=%b err=%b stall=%0d",
                 e.nm, ctl, mem_err, stall_cycles, e.ctl, e.err, e.stall);
      end
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      next_cyc();
      if (i < 4) begin
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        sb.push_back('{"mw_hold", HALL, (i == 3), 3'(i)});
      end else if (i == 4) begin
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        sb.push_back('{"mw_release", NONE, 1'b0, 3'd4});
      end else begin
        idle();
        sb.push_back('{"mw_idle", NONE, 1'b0, 3'd4});
      end
      @(negedge clk);
      e = sb.pop_front(); n_run++;
      if ({ctl, mem_err, stall_cycles} !== {e.ctl, e.err, e.stall}) begin
        n_fail++;
        $display("FAIL %s[%0d]: got ctl=%b err=%b stall=%0d want ctl=%b err=%b stall=%0d",
                 e.nm, i, ctl, mem_err, stall_cycles, e.ctl, e.err, e.stall);
      end
    end
  endtask

  task automatic test_mem_wait_redirect();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      next_cyc();
      if (i < 4) begin
        set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
        sb.push_back('{"mwr_frozen", HALL, (i == 3), 3'(i)});
      end else if (i == 4) begin
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        sb.push_back('{"mwr_release_redirect", RD, 1'b0, 3'd4});
      end else if (i == 5 || i == 6) begin
        idle();
        sb.push_back('{"mwr_bubble", BUB, 1'b0, 3'd4});
      end else if (i == 7) begin
        idle();
        sb.push_back('{"mwr_done", NONE, 1'b0, 3'd4});
      end else if (i == 8) begin
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        sb.push_back('{"mwr_redirect2", RD, 1'b0, 3'd4});
      end else if (i == 9 || i == 10) begin
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        sb.push_back('{"mwr_stall_in_redirect", HALL, 1'b0, 3'(i - 5)});
      end else if (i == 11 || i == 12) begin
        idle();
        sb.push_back('{"mwr_count_preserved", BUB, 1'b0, 3'd6});
      end else begin
        idle();
        sb.push_back('{"mwr_done2", NONE, 1'b0, 3'd6});
      end
      @(negedge clk);
      e = sb.pop_front(); n_run++;
      if ({ctl, mem_err, stall_cycles} !== {e.ctl, e.err, e.stall}) begin
        n_fail++;
        $display("FAIL %s[%0d]: got ctl=%b err=%b stall=%0d want ctl=%b err=%b stall=%0d",
                 e.nm, i, ctl, mem_err, stall_cycles, e.ctl, e.err, e.stall);
      end
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      next_cyc();
      if (i < 7) begin
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        sb.push_back('{"wd_stall", HALL, (i == 3 || i == 6), 3'(i)});
      end else begin
        idle();
        sb.push_back('{"wd_release", NONE, 1'b0, 3'd7});
      end
      @(negedge clk);
      e = sb.pop_front(); n_run++;
      if ({ctl, mem_err, stall_cycles} !== {e.ctl, e.err, e.stall}) begin
        n_fail++;
        $display("FAIL %s[%0d]: got ctl=%b err=%b stall=%0d want ctl=%b err=%b stall=%0d",
                 e.nm, i, ctl, mem_err, stall_cycles, e.ctl, e.err, e.stall);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 11; i++) begin
      next_cyc();
      if (i < 10) begin
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        sb.push_back('{"sat_stall", HALL, (i > 0 && i % 3 == 0), 3'((i > 7) ? 7 : i)});
      end else begin
        idle();
        sb.push_back('{"sat_final", NONE, 1'b0, 3'd7});
      end
      @(negedge clk);
      e = sb.pop_front(); n_run++;
      if ({ctl, mem_err, stall_cycles} !== {e.ctl, e.err, e.stall}) begin
        n_fail++;
        $display("FAIL %s[%0d]: got ctl=%b err=%b stall=%0d want ctl=%b err=%b stall=%0d",
                 e.nm, i, ctl, mem_err, stall_cycles, e.ctl, e.err, e.stall);
      end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i != 2 && i != 5) next_cyc();
      case (i)
        0: begin set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); sb.push_back('{"rm_redirect", RD, 1'b0, 3'd0}); end
        1: begin idle(); sb.push_back('{"rm_in_redirect", BUB, 1'b0, 3'd0}); end
        2: begin rst = 1'b1; sb.push_back('{"rm_rst_redirect", NONE, 1'b0, 3'd0}); end
        3: begin rst = 1'b0; set_in(1, 5, 5, 0, 1, 0, 0, 0, 0); sb.push_back('{"rm_run_after_rst", LU, 1'b0, 3'd0}); end
        4: begin set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); sb.push_back('{"rm_stall", HALL, 1'b0, 3'd1}); end
        5: begin rst = 1'b1; sb.push_back('{"rm_rst_stall", NONE, 1'b0, 3'd0}); end
        default: begin rst = 1'b0; idle(); sb.push_back('{"rm_idle_after_rst", NONE, 1'b0, 3'd0}); end
      endcase
      if (i == 2 || i == 5) #1;
      else @(negedge clk);
      e = sb.pop_front(); n_run++;
      if ({ctl, mem_err, stall_cycles} !== {e.ctl, e.err, e.stall}) begin
        n_fail++;
        $display("FAIL %s: got ctl=%b err=%b stall=%0d want ctl=%b err=%b stall=%0d",
                 e.nm, ctl, mem_err, stall_cycles, e.ctl, e.err, e.stall);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_mem_wait_redirect();
    test_watchdog();
    test_saturation();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
